imem_stream_loader: RTL and testbench



---
 rtl/imem_stream_loader.sv | 135 +++++++++++++
 tb/tb_imem_stream_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - byte-stream boot loader for instruction memory
// Assembles streamed bytes (first byte = bits 31:24) into 32-bit words and
// writes them to consecutive instruction-memory addresses starting at 0,
// holding the processor until the whole program has been written.
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   start, load_len            begin a load of load_len words (1..DEPTH)
//   byte_in, byte_valid,
//   byte_ready                 input byte stream handshake
//   imem_we, imem_addr,
//   imem_wdata                 instruction-memory write port
//   cpu_hold, done, error      processor hold, load complete, load aborted
module imem_stream_loader #(
   parameter int ADDR_W  = 10,
   parameter int DEPTH   = 1024,
   parameter int TIMEOUT = 1000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WRITE_LAST, DONE, ERROR} state_t;

   state_t          state, state_nx;
   logic [ADDR_W:0] len;
   logic [ADDR_W:0] word_idx;     // one bit wider so a DEPTH-word load never wraps
   logic [1:0]      byte_cnt;
   logic [TW-1:0]   tmo;
   logic [23:0]     shift;        // first three bytes; the fourth comes straight from byte_in
   logic            xfer;
   logic            len_ok;
   logic            last_word;
   logic            load_begin;

   assign xfer       = byte_valid && (state == LOAD);
   assign len_ok     = (load_len != '0) && (load_len <= DEPTH_L);
   assign last_word  = (word_idx == len - ONE);
   assign load_begin = (state != LOAD) && (state_nx == LOAD);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      byte_ready = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         IDLE: begin
            if (start) state_nx = len_ok ? LOAD : ERROR;
         end
         LOAD: begin
            byte_ready = 1'b1;
            if (xfer && (byte_cnt == 2'd3) && last_word) begin
               state_nx = WRITE_LAST;
            end else if (!xfer && (tmo == TMO_LAST)) begin
               state_nx = ERROR;
            end
         end
         WRITE_LAST: begin
            state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_nx = len_ok ? LOAD : ERROR;
         end
         ERROR: begin
            error = 1'b1;
            if (start) state_nx = len_ok ? LOAD : ERROR;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The write strobe is registered: the 4th-byte transfer sets it for exactly
   // the following cycle, which for the final word is the WRITE_LAST cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         len        <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         tmo        <= '0;
         shift      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (load_begin) begin
            len      <= load_len;
            word_idx <= '0;
            byte_cnt <= '0;
            tmo      <= '0;
         end else if (state == LOAD) begin
            if (xfer) begin
               shift    <= {shift[15:0], byte_in};
               byte_cnt <= byte_cnt + 2'd1;
               tmo      <= '0;
               if (byte_cnt == 2'd3) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_idx[ADDR_W-1:0];
                  imem_wdata <= {shift, byte_in};
                  word_idx   <= word_idx + ONE;
               end
            end else begin
               tmo <= tmo + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - self-checking bench for imem_stream_loader
module tb_imem_stream_loader;

   localparam int ADDR_W  = 10;
   localparam int DEPTH   = 1024;
   localparam int TIMEOUT = 1000;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   load_len;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          done_cyc = -1;
   int          first_xfer;
   int          last_xfer;
   bit          send_ok;
   int          wq_addr[$];
   logic [31:0] wq_data[$];
   int          wq_cyc[$];
   logic [31:0] tx_words[$];

   imem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .start(start), .load_len(load_len),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (imem_we) begin
         wq_addr.push_back(int'(imem_addr));
         wq_data.push_back(imem_wdata);
         wq_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
   end

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
      done_cyc = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      clear_log();
   endtask

   task automatic pulse_start(input int n);
      load_len = n[ADDR_W:0];
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Streams nbytes of tx_words, most significant byte first.
   task automatic send_bytes(input int nbytes, input int gap, input bit rnd);
      logic [31:0] w;
      int k, g;
      send_ok = 1'b1;
      for (int j = 0; j < nbytes; j++) begin
         w = tx_words[j / 4];
         byte_in = w[8 * (3 - j % 4) +: 8];
         byte_valid = 1'b1;
         k = 0;
         while (!byte_ready && k < 50) begin @(posedge clock); #1; k++; end
         if (!byte_ready) begin send_ok = 1'b0; byte_valid = 1'b0; return; end
         @(posedge clock); #1;
         if (j == 0) first_xfer = cyc;
         last_xfer = cyc;
         byte_valid = 1'b0;
         g = rnd ? int'($urandom_range(gap, 0)) : gap;
         repeat (g) begin @(posedge clock); #1; end
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 20) begin @(posedge clock); #1; k++; end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready got %b exp 0", byte_ready); end
      n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_imem_we got %b exp 0", imem_we); end
      n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
      n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_imem_wdata got %h exp 0", imem_wdata); end
      n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b exp 0", error); end
      byte_valid = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;
      n_checks++; if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL idle_outputs got ready=%b hold=%b exp ready=0 hold=1", byte_ready, cpu_hold); end
   endtask

   // gap = 0 is the back-to-back case; gap = 3 inserts idle cycles between bytes.
   task automatic test_two_words(input int gap, input string tag);
      do_reset();
      tx_words = '{32'h8C010004, 32'h00000008};
      pulse_start(2);
      send_bytes(8, gap, 1'b0);
      n_checks++; if (!send_ok) begin n_fail++; $display("FAIL %s_stream got stalled exp accepted", tag); end
      wait_done();
      repeat (3) begin @(posedge clock); #1; end
      n_checks++; if (wq_addr.size() != 2) begin n_fail++; $display("FAIL %s_write_count got %0d exp 2", tag, wq_addr.size()); end
      for (int i = 0; i < 2 && i < wq_addr.size(); i++) begin
         n_checks++;
         if (wq_addr[i] != i || wq_data[i] !== tx_words[i]) begin
            n_fail++; $display("FAIL %s_write%0d got addr %0d data %h exp addr %0d data %h", tag, i, wq_addr[i], wq_data[i], i, tx_words[i]);
         end
      end
      n_checks++; if (last_xfer - first_xfer != 7 * (gap + 1)) begin n_fail++; $display("FAIL %s_xfer_span got %0d exp %0d", tag, last_xfer - first_xfer, 7 * (gap + 1)); end
      if (wq_cyc.size() == 2) begin
         n_checks++; if (wq_cyc[1] != last_xfer) begin n_fail++; $display("FAIL %s_last_we_cycle got %0d exp %0d", tag, wq_cyc[1], last_xfer); end
         n_checks++; if (done_cyc != wq_cyc[1] + 1) begin n_fail++; $display("FAIL %s_done_cycle got %0d exp %0d", tag, done_cyc, wq_cyc[1] + 1); end
      end
      n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL %s_final got done=%b hold=%b err=%b exp 1 0 0", tag, done, cpu_hold, error); end
   endtask

   task automatic test_illegal_len();
      int lens[2] = '{0, DEPTH + 1};
      for (int i = 0; i < 2; i++) begin
         do_reset();
         pulse_start(lens[i]);
         n_checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL illegal_len%0d got err=%b hold=%b done=%b exp 1 1 0", lens[i], error, cpu_hold, done); end
         repeat (4) begin @(posedge clock); #1; end
         n_checks++; if (wq_addr.size() != 0 || error !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL illegal_hold%0d got writes=%0d err=%b hold=%b exp 0 1 1", lens[i], wq_addr.size(), error, cpu_hold); end
      end
      pulse_start(1);
      n_checks++; if (error !== 1'b0 || byte_ready !== 1'b1) begin n_fail++; $display("FAIL error_restart got err=%b ready=%b exp 0 1", error, byte_ready); end
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      tx_words = '{$urandom, $urandom, $urandom};
      pulse_start(3);
      send_bytes(6, 0, 1'b0);
      while (!error && n < TIMEOUT + 10) begin @(posedge clock); #1; n++; end
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error got %b exp 1", error); end
      n_checks++; if (n < TIMEOUT - 1 || n > TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_cycles got %0d exp %0d", n, TIMEOUT); end
      repeat (5) begin @(posedge clock); #1; end
      n_checks++; if (wq_addr.size() != 1) begin n_fail++; $display("FAIL timeout_write_count got %0d exp 1", wq_addr.size()); end
      else begin
         n_checks++; if (wq_addr[0] != 0 || wq_data[0] !== tx_words[0]) begin n_fail++; $display("FAIL timeout_write got addr %0d data %h exp 0 %h", wq_addr[0], wq_data[0], tx_words[0]); end
      end
      n_checks++; if (cpu_hold !== 1'b1 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_hold got hold=%b ready=%b exp 1 0", cpu_hold, byte_ready); end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      tx_words = '{$urandom, $urandom, $urandom, $urandom};
      pulse_start(4);
      send_bytes(5, 0, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;
      n_checks++; if (byte_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0) begin
         n_fail++; $display("FAIL midreset_datapath got ready=%b we=%b addr=%h data=%h exp 0 0 0 0", byte_ready, imem_we, imem_addr, imem_wdata);
      end
      n_checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL midreset_status got hold=%b done=%b err=%b exp 1 0 0", cpu_hold, done, error); end
      reset = 1'b0;
      clear_log();
      repeat (3) begin @(posedge clock); #1; end
      n_checks++; if (wq_addr.size() != 0) begin n_fail++; $display("FAIL midreset_no_write got %0d exp 0", wq_addr.size()); end
      tx_words = '{$urandom};
      pulse_start(1);
      send_bytes(4, 0, 1'b0);
      wait_done();
      n_checks++; if (wq_addr.size() != 1 || wq_addr[0] != 0 || wq_data[0] !== tx_words[0] || done !== 1'b1) begin
         n_fail++; $display("FAIL midreset_restart got writes=%0d done=%b exp 1 write of %h at 0, done=1", wq_addr.size(), done, tx_words[0]);
      end
   endtask

   task automatic test_random_loads();
      int len;
      do_reset();
      for (int it = 0; it < 5; it++) begin
         len = int'($urandom_range(6, 1));
         tx_words.delete();
         for (int i = 0; i < len; i++) tx_words.push_back($urandom);
         clear_log();
         pulse_start(len);
         send_bytes(4 * len, 3, 1'b1);
         wait_done();
         n_checks++; if (wq_addr.size() != len || done !== 1'b1) begin n_fail++; $display("FAIL random%0d_count got %0d done=%b exp %0d done=1", it, wq_addr.size(), done, len); end
         for (int i = 0; i < len && i < wq_addr.size(); i++) begin
            n_checks++;
            if (wq_addr[i] != i || wq_data[i] !== tx_words[i]) begin
               n_fail++; $display("FAIL random%0d_write%0d got addr %0d data %h exp %0d %h", it, i, wq_addr[i], wq_data[i], i, tx_words[i]);
            end
         end
      end
   endtask

   task automatic test_full_depth();
      int bad = 0;
      int bad_idx = -1;
      do_reset();
      tx_words.delete();
      for (int i = 0; i < DEPTH; i++) tx_words.push_back(32'(i));
      pulse_start(DEPTH);
      send_bytes(4 * DEPTH, 0, 1'b0);
      wait_done();
      repeat (2) begin @(posedge clock); #1; end
      n_checks++; if (wq_addr.size() != DEPTH) begin n_fail++; $display("FAIL full_count got %0d exp %0d", wq_addr.size(), DEPTH); end
      for (int i = 0; i < wq_addr.size(); i++) begin
         if (i >= DEPTH || wq_addr[i] != i || wq_data[i] !== tx_words[i]) begin
            bad++;
            if (bad_idx < 0) bad_idx = i;
         end
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_words got %0d bad (first at %0d) exp 0", bad, bad_idx); end
      if (wq_addr.size() > 0) begin
         n_checks++; if (wq_addr[wq_addr.size() - 1] != DEPTH - 1 || wq_data[wq_data.size() - 1] !== 32'h000003FF) begin
            n_fail++; $display("FAIL full_last got addr %0d data %h exp 1023 000003ff", wq_addr[wq_addr.size() - 1], wq_data[wq_data.size() - 1]);
         end
      end
      n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL full_done got done=%b hold=%b exp 1 0", done, cpu_hold); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
      test_reset();
      test_two_words(0, "back_to_back");
      test_two_words(3, "gapped");
      test_illegal_len();
      test_timeout();
      test_reset_mid_load();
      test_random_loads();
      test_full_depth();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
